pow_dispatch: RTL

POW_DISPATCH -- requirements
Module: pow_dispatch

---
 rtl/pow_dispatch_pkg.sv | 23 ++
 rtl/pow_req_fifo.sv | 65 ++++++
 rtl/pow_dispatch.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pow_dispatch_pkg.sv
// Shared types and constants for the modular-exponentiation dispatcher.
package pow_dispatch_pkg;

  localparam int unsigned DefaultW    = 128;
  localparam int unsigned DefaultTagW = 4;

  // Cycles after pow_start during which pow_valid is treated as stale.
  localparam int unsigned BlankCyc = 2;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StBlank,
    StWait,
    StHold
  } state_e;

  // Width of one queued request: tag, modulus, exponent, base.
  function automatic int unsigned req_data_w(input int unsigned w, input int unsigned tag_w);
    return 3 * w + tag_w;
  endfunction

endpackage

// File: rtl/pow_req_fifo.sv
// Request FIFO for pow_dispatch: DEPTH entries (power of two), registered
// count, full/empty derived from the count. Pushes while full and pops while
// empty are dropped, so a push is never taken on a full FIFO even if a pop
// happens in the same cycle.
module pow_req_fifo
  import pow_dispatch_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PtrW-1:0]   wr_ptr;
  logic [PtrW-1:0]   rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CntW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy 0..DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pow_dispatch.sv
// Dispatcher in front of a single modular-exponentiation engine. Requests are
// queued in pow_req_fifo and issued one at a time; each result is held on the
// response port until accepted. pow_valid is ignored for BlankCyc cycles after
// every issue so a valid left high by the previous job is never captured.
// Optional watchdog: define POW_DISPATCH_TIMEOUT_EN to return rsp_err=1 after
// TIMEOUT_CYC cycles in BLANK/WAIT without a result.
module pow_dispatch
  import pow_dispatch_pkg::*;
#(
  parameter int unsigned W           = DefaultW,
  parameter int unsigned TAG_W       = DefaultTagW,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [W-1:0]     req_a,
  input  logic [W-1:0]     req_b,
  input  logic [W-1:0]     req_p,
  input  logic [TAG_W-1:0] req_tag,
  output logic             pow_start,
  output logic [W-1:0]     pow_a,
  output logic [W-1:0]     pow_b,
  output logic [W-1:0]     pow_p,
  input  logic [W-1:0]     pow_res,
  input  logic             pow_valid,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_res,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err
);

  localparam int unsigned DataW = req_data_w(W, TAG_W);
  localparam int unsigned CntW  = $clog2(DEPTH) + 1;

  state_e           state;
  logic [DataW-1:0] fifo_din;
  logic [DataW-1:0] fifo_dout;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CntW-1:0]  fifo_count;
  logic             issue_go;
  logic [TAG_W-1:0] job_tag;
  logic [1:0]       blank_cnt;

  assign fifo_din  = {req_tag, req_p, req_b, req_a};
  assign req_ready = !fifo_full;
  assign fifo_push = req_valid && req_ready;
  // Pop on the IDLE->ISSUE edge so the operands are valid during the ISSUE cycle.
  assign issue_go  = (state == StIdle) && !fifo_empty && !rsp_valid;
  assign fifo_pop  = issue_go;

  pow_req_fifo #(
    .DATA_W (DataW),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef POW_DISPATCH_TIMEOUT_EN
  logic [31:0] to_cnt;
  logic        rsp_err_q;
  logic        timeout_hit;

  assign timeout_hit = (to_cnt + 32'd1) >= TIMEOUT_CYC;
  assign rsp_err     = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Dispatch FSM with all engine and response outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      pow_start <= 1'b0;
      pow_a     <= '0;
      pow_b     <= '0;
      pow_p     <= '0;
      job_tag   <= '0;
      blank_cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_res   <= '0;
      rsp_tag   <= '0;
`ifdef POW_DISPATCH_TIMEOUT_EN
      to_cnt    <= '0;
      rsp_err_q <= 1'b0;
`endif
    end else begin
      pow_start <= 1'b0;
`ifdef POW_DISPATCH_TIMEOUT_EN
      if (state == StBlank || state == StWait) begin
        to_cnt <= to_cnt + 32'd1;
      end
`endif
      unique case (state)
        StIdle: begin
          if (issue_go) begin
            state     <= StIssue;
            pow_start <= 1'b1;
            pow_a     <= fifo_dout[W-1:0];
            pow_b     <= fifo_dout[2*W-1:W];
            pow_p     <= fifo_dout[3*W-1:2*W];
            job_tag   <= fifo_dout[DataW-1:3*W];
          end
        end
        StIssue: begin
          state     <= StBlank;
          blank_cnt <= '0;
`ifdef POW_DISPATCH_TIMEOUT_EN
          to_cnt    <= '0;
`endif
        end
        StBlank: begin
          if (blank_cnt == 2'(BlankCyc - 1)) begin
            state <= StWait;
          end else begin
            blank_cnt <= blank_cnt + 2'd1;
          end
`ifdef POW_DISPATCH_TIMEOUT_EN
          if (timeout_hit) begin
            state     <= StHold;
            rsp_valid <= 1'b1;
            rsp_res   <= '0;
            rsp_tag   <= job_tag;
            rsp_err_q <= 1'b1;
          end
`endif
        end
        StWait: begin
          if (pow_valid) begin
            state     <= StHold;
            rsp_valid <= 1'b1;
            rsp_res   <= pow_res;
            rsp_tag   <= job_tag;
`ifdef POW_DISPATCH_TIMEOUT_EN
            rsp_err_q <= 1'b0;
          end else if (timeout_hit) begin
            state     <= StHold;
            rsp_valid <= 1'b1;
            rsp_res   <= '0;
            rsp_tag   <= job_tag;
            rsp_err_q <= 1'b1;
`endif
          end
        end
        StHold: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Parameter sanity and FIFO status consistency, checked in simulation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (fifo_full == (fifo_count == CntW'(DEPTH)));
      assert (DEPTH >= 2 && (DEPTH & (DEPTH - 1)) == 0);
      assert (TIMEOUT_CYC != 0);
    end
  end

endmodule
